// File: rtl/iopage_pkg.sv
// Shared definitions for the I/O-page sequencer: widths, device addresses, state
// encoding and the latched CPU request.
package iopage_pkg;
    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;

    localparam logic [ADDR_W-1:0] SR_ADDR  = 13'o17570;
    localparam logic [ADDR_W-1:0] CON_ADDR = 13'o17560;
    localparam logic [ADDR_W-1:0] CLK_ADDR = 13'o17546;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_STROBE,
        ST_ACK,
        ST_NXM
    } state_t;

    typedef struct packed {
        logic              wr;
        logic              byte_op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

    // A single device still needs a one-bit select.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/iopage_rdmux.sv
// Priority encoder over device decodes plus the read-data mux, indexed by the
// select the controller registered during DECODE.
module iopage_rdmux
    import iopage_pkg::*;
#(
    parameter int NDEV = 4,
    localparam int SW = sel_w(NDEV)
) (
    input  logic [NDEV-1:0]        dev_decode,
    input  logic [NDEV*DATA_W-1:0] dev_data,
    input  logic [SW-1:0]          data_sel,
    output logic                   any_decode,
    output logic [SW-1:0]          sel,
    output logic                   multi,
    output logic [DATA_W-1:0]      data
);
    logic [NDEV-1:0][DATA_W-1:0] words;

    assign words      = dev_data;
    assign any_decode = |dev_decode;
    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi      = |(dev_decode & (dev_decode - NDEV'(1)));
    assign data       = words[data_sel];

    always_comb begin
        sel = '0;
        for (int i = NDEV - 1; i >= 0; i--)
            if (dev_decode[i]) sel = SW'(i);
    end
endmodule

// File: rtl/iopage_ctl.sv
// CPU-to-I/O-page sequencer: latch one request, wait for a device decode (or time
// out to NXM), issue a single strobe, then hold ack until the CPU drops its request.
module iopage_ctl
    import iopage_pkg::*;
#(
    parameter int NDEV    = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bus_req,
    input  logic                   bus_wr,
    input  logic                   bus_byte_op,
    input  logic [ADDR_W-1:0]      bus_addr,
    input  logic [DATA_W-1:0]      bus_data_in,
    output logic [DATA_W-1:0]      bus_data_out,
    output logic                   bus_ack,
    output logic                   bus_nxm,
    output logic [ADDR_W-1:0]      iopage_addr,
    output logic [DATA_W-1:0]      iopage_data_in,
    output logic                   iopage_rd,
    output logic                   iopage_wr,
    output logic                   iopage_byte_op,
    input  logic [NDEV-1:0]        dev_decode,
    input  logic [NDEV*DATA_W-1:0] dev_data_out,
    output logic                   multi_decode
);
    localparam int SW = sel_w(NDEV);

    state_t            state, state_nx;
    req_t              req_q;
    logic [7:0]        cnt;
    logic [SW-1:0]     sel_q, sel_now;
    logic              any_dec, multi_now;
    logic [DATA_W-1:0] rd_word;

    iopage_rdmux #(.NDEV(NDEV)) u_rdmux (
        .dev_decode (dev_decode),
        .dev_data   (dev_data_out),
        .data_sel   (sel_q),
        .any_decode (any_dec),
        .sel        (sel_now),
        .multi      (multi_now),
        .data       (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:   if (bus_req) state_nx = ST_DECODE;
            ST_DECODE: begin
                if (any_dec)                       state_nx = ST_STROBE;
                else if (cnt == 8'(TIMEOUT - 1))  state_nx = ST_NXM;
            end
            ST_STROBE: state_nx = ST_ACK;
            ST_ACK,
            ST_NXM:    if (!bus_req) state_nx = ST_IDLE;
            default:   state_nx = ST_IDLE;
        endcase
    end

    // Strobes and ack decode straight from state so reset removes them at once.
    always_comb begin
        iopage_rd = (state == ST_STROBE) && !req_q.wr;
        iopage_wr = (state == ST_STROBE) &&  req_q.wr;
        bus_ack   = (state == ST_ACK) || (state == ST_NXM);
        bus_nxm   = (state == ST_NXM);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q        <= '0;
            cnt          <= '0;
            sel_q        <= '0;
            multi_decode <= 1'b0;
            bus_data_out <= '0;
        end else begin
            if (state == ST_IDLE && bus_req) begin
                req_q <= '{wr: bus_wr, byte_op: bus_byte_op, addr: bus_addr, data: bus_data_in};
                cnt   <= '0;
            end
            if (state == ST_DECODE) begin
                if (any_dec) begin
                    sel_q <= sel_now;
                    if (multi_now) multi_decode <= 1'b1;
                end else begin
                    cnt <= cnt + 8'd1;
                end
            end
            if (state == ST_STROBE && !req_q.wr)
                bus_data_out <= rd_word;
        end
    end

    assign iopage_addr    = req_q.addr;
    assign iopage_byte_op = req_q.byte_op;
    // Byte writes replicate the low byte; the device picks the lane from addr[0].
    assign iopage_data_in = req_q.byte_op ? {2{req_q.data[7:0]}} : req_q.data;
endmodule
